// File: rtl/sdram_arbiter.sv
// Two-port arbiter in front of sdram_controller: port 0 (flash-emulation reads) has
// fixed priority, port 1 (command parser) is forced through after MAX_WAIT lost grants.
module sdram_arbiter #(
    parameter int ADDR_BITS = 25,
    parameter int MAX_WAIT  = 8,
    parameter int TIMEOUT   = 64
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic [ADDR_BITS-1:0] p0_addr,
    input  logic                 p0_enable,
    output logic                 p0_busy,
    output logic [7:0]           p0_rd_data,
    output logic                 p0_rd_ready,
    output logic                 p0_timeout,

    input  logic [ADDR_BITS-1:0] p1_addr,
    input  logic                 p1_we,
    input  logic [7:0]           p1_wr_data,
    input  logic                 p1_enable,
    input  logic                 p1_refresh_inhibit,
    output logic                 p1_busy,
    output logic [7:0]           p1_rd_data,
    output logic                 p1_rd_ready,

    output logic [ADDR_BITS-1:0] sd_addr,
    output logic                 sd_we,
    output logic [7:0]           sd_wr_data,
    output logic                 sd_enable,
    output logic                 sd_refresh_inhibit,
    input  logic [7:0]           sd_rd_data,
    input  logic                 sd_rd_ready,
    input  logic                 sd_busy
);

    localparam int STARVE_W = $clog2(MAX_WAIT + 1);
    localparam int WAIT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } state_t;

    state_t state_q, state_d;

    logic                 p0_pend, p1_pend;
    logic [ADDR_BITS-1:0] p0_addr_q, p1_addr_q;
    logic                 p1_we_q;
    logic [7:0]           p1_data_q;
    logic                 owner_q;      // 0 = port 0, 1 = port 1
    logic [STARVE_W-1:0]  starve_q;
    logic [WAIT_W-1:0]    wait_cnt;

    logic grant, grant_p1, rd_done, wr_done, rd_abort;
    logic p0_accept, p1_accept;

    assign p0_accept = p0_enable && !p0_busy;
    assign p1_accept = p1_enable && !p1_busy;

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first, so no path leaves a
    // variable unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        grant    = 1'b0;
        grant_p1 = 1'b0;
        rd_done  = 1'b0;
        wr_done  = 1'b0;
        rd_abort = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if ((p0_pend || p1_pend) && !sd_busy) begin
                    grant    = 1'b1;
                    grant_p1 = p1_pend && (!p0_pend || starve_q == STARVE_W'(MAX_WAIT));
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (!sd_we) begin
                    if (sd_rd_ready)                         rd_done  = 1'b1;
                    else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) rd_abort = 1'b1;
                end else if (wait_cnt != '0 && !sd_busy) begin
                    // first write cycle is skipped so the controller has time to raise sd_busy
                    wr_done = 1'b1;
                end
                if (rd_done || wr_done || rd_abort) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            p0_pend            <= 1'b0;
            p1_pend            <= 1'b0;
            p0_addr_q          <= '0;
            p1_addr_q          <= '0;
            p1_we_q            <= 1'b0;
            p1_data_q          <= 8'h00;
            owner_q            <= 1'b0;
            starve_q           <= '0;
            wait_cnt           <= '0;
            p0_busy            <= 1'b0;
            p1_busy            <= 1'b0;
            p0_rd_data         <= 8'h00;
            p1_rd_data         <= 8'h00;
            p0_rd_ready        <= 1'b0;
            p1_rd_ready        <= 1'b0;
            p0_timeout         <= 1'b0;
            sd_addr            <= '0;
            sd_we              <= 1'b0;
            sd_wr_data         <= 8'h00;
            sd_enable          <= 1'b0;
            sd_refresh_inhibit <= 1'b0;
        end else begin
            sd_enable   <= 1'b0;
            p0_rd_ready <= 1'b0;
            p1_rd_ready <= 1'b0;
            p0_timeout  <= 1'b0;

            if (p0_accept) begin
                p0_pend   <= 1'b1;
                p0_busy   <= 1'b1;
                p0_addr_q <= p0_addr;
            end
            if (p1_accept) begin
                p1_pend   <= 1'b1;
                p1_busy   <= 1'b1;
                p1_addr_q <= p1_addr;
                p1_we_q   <= p1_we;
                p1_data_q <= p1_wr_data;
            end

            if (grant) owner_q <= grant_p1;
            if (grant && !grant_p1 && p1_pend) starve_q <= starve_q + STARVE_W'(1);
            else if (grant_p1 || !p1_pend)      starve_q <= '0;

            if (state_q == ST_ISSUE) begin
                sd_enable <= 1'b1;
                if (owner_q) begin
                    sd_addr    <= p1_addr_q;
                    sd_we      <= p1_we_q;
                    sd_wr_data <= p1_data_q;
                    p1_pend    <= 1'b0;
                end else begin
                    sd_addr    <= p0_addr_q;
                    sd_we      <= 1'b0;
                    sd_wr_data <= 8'h00;
                    p0_pend    <= 1'b0;
                end
            end

            if (state_q == ST_WAIT) begin
                if (wait_cnt != '1) wait_cnt <= wait_cnt + WAIT_W'(1);
            end else begin
                wait_cnt <= '0;
            end

            if (rd_done) begin
                if (owner_q) begin
                    p1_rd_data  <= sd_rd_data;
                    p1_rd_ready <= 1'b1;
                    p1_busy     <= 1'b0;
                end else begin
                    p0_rd_data  <= sd_rd_data;
                    p0_rd_ready <= 1'b1;
                    p0_busy     <= 1'b0;
                end
            end
            if (wr_done) p1_busy <= 1'b0;
            if (rd_abort) begin
                if (owner_q) begin
                    p1_busy <= 1'b0;
                end else begin
                    p0_busy    <= 1'b0;
                    p0_timeout <= 1'b1;
                end
            end

            sd_refresh_inhibit <= p1_refresh_inhibit || (!owner_q && state_q != ST_IDLE);
        end
    end

endmodule
